// File: rtl/mdr_seq_unit_pkg.sv
// Shared types for the sequential multiply/divide/root unit.
// Holds the opcode and FSM state enums plus the default operand width.
package pkg_mdr_seq;

    localparam int DW_DEF = 16;

    typedef enum logic [1:0] {
        OP_MULT = 2'd0,
        OP_DIV  = 2'd1,
        OP_ROOT = 2'd2,
        OP_RSVD = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_X,
        LOAD_Y,
        CALC,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/mdr_seq_unit_if.sv
// Operand/result bus of mdr_seq_unit.
// master: i_start/i_load/i_data/i_op out, status and results in.
// slave : the unit side, directions reversed.
interface mdr_seq_unit_if #(
    parameter int DW = pkg_mdr_seq::DW_DEF
) ();

    logic            i_start;
    logic            i_load;
    logic [DW-1:0]   i_data;
    logic [1:0]      i_op;
    logic            o_load_x;
    logic            o_load_y;
    logic            o_busy;
    logic            o_ready;
    logic            o_error;
    logic [2*DW-1:0] o_result;
    logic [DW-1:0]   o_remainder;

    modport master (
        output i_start, i_load, i_data, i_op,
        input  o_load_x, o_load_y, o_busy, o_ready,
        input  o_error, o_result, o_remainder
    );

    modport slave (
        input  i_start, i_load, i_data, i_op,
        output o_load_x, o_load_y, o_busy, o_ready,
        output o_error, o_result, o_remainder
    );

endinterface

// File: rtl/mdr_seq_unit_iter_cnt.sv
// Iteration counter: clk/rst, i_clr, i_en, i_tc_val in; o_tc out.
// o_tc is high while enabled and the count equals i_tc_val.
module mdr_iter_cnt #(
    parameter int DW = 16,
    parameter int CW = $clog2(DW + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic [CW-1:0] i_tc_val,
    output logic          o_tc
);

    logic [CW-1:0] cnt_q;

    assign o_tc = i_en && (cnt_q == i_tc_val);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (i_clr) begin
            cnt_q <= '0;
        end else if (i_en && !o_tc) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/mdr_seq_unit.sv
// Sequential unsigned MULT/DIV/ROOT unit on one shared DW+2 add/sub.
// Ports: clk, rst (async, active-high), bus (mdr_seq_unit_if.slave).
// Macro MDR_ROOT_EN enables the square-root datapath.
module mdr_seq_unit
    import pkg_mdr_seq::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    mdr_seq_unit_if.slave bus
);

    localparam int W  = DW + 2;
    localparam int CW = $clog2(DW + 1);

    state_t          state_q;
    op_t             op_q;
    logic [DW-1:0]   x_q, y_q, r_q;
    logic [DW-1:0]   x_d, y_d, r_d;
    logic [2*DW-1:0] res_q, res_d;
    logic [DW-1:0]   rem_q, rem_d;
    logic            load_x_q, load_y_q;
    logic            busy_q, ready_q, error_q;
    logic [W-1:0]    opa, opb, sum;
    logic            sub, ge, tc, bad_op;
    logic [CW-1:0]   n_iter;

    // Operands never reach the top bit, so it acts as the borrow.
    assign sum = opa + (opb ^ {W{sub}}) + W'(sub);
    assign ge  = ~sum[W-1];

`ifdef MDR_ROOT_EN
    assign bad_op = (op_q == OP_RSVD);
    assign n_iter = (op_q == OP_ROOT) ? CW'(DW / 2) : CW'(DW);
`else
    assign bad_op = (op_q == OP_RSVD) || (op_q == OP_ROOT);
    assign n_iter = CW'(DW);
`endif

    always_comb begin
        opa = '0;
        opb = '0;
        sub = 1'b0;
        unique case (op_q)
            OP_MULT: begin
                opa = {2'b00, r_q};
                opb = x_q[0] ? {2'b00, y_q} : '0;
            end
            OP_DIV: begin
                opa = {1'b0, r_q, x_q[DW-1]};
                opb = {2'b00, y_q};
                sub = 1'b1;
            end
`ifdef MDR_ROOT_EN
            // Trial subtract of 4*root+1 from remainder:next2bits.
            OP_ROOT: begin
                opa = {r_q, x_q[DW-1:DW-2]};
                opb = {y_q, 2'b01};
                sub = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        r_d   = r_q;
        res_d = {r_q, x_q};
        rem_d = '0;
        unique case (op_q)
            OP_MULT: begin
                r_d = sum[DW:1];
                x_d = {sum[0], x_q[DW-1:1]};
            end
            OP_DIV: begin
                r_d   = ge ? sum[DW-1:0]
                           : {r_q[DW-2:0], x_q[DW-1]};
                x_d   = {x_q[DW-2:0], ge};
                res_d = {{DW{1'b0}}, x_q};
                rem_d = r_q;
            end
`ifdef MDR_ROOT_EN
            OP_ROOT: begin
                r_d   = ge ? sum[DW-1:0]
                           : {r_q[DW-3:0], x_q[DW-1:DW-2]};
                x_d   = {x_q[DW-3:0], 2'b00};
                y_d   = {y_q[DW-2:0], ge};
                res_d = {{DW{1'b0}}, y_q};
                rem_d = r_q;
            end
`endif
            default: ;
        endcase
    end

    mdr_iter_cnt #(
        .DW (DW)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (state_q != CALC),
        .i_en     (state_q == CALC),
        .i_tc_val (n_iter),
        .o_tc     (tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_MULT;
            x_q      <= '0;
            y_q      <= '0;
            r_q      <= '0;
            res_q    <= '0;
            rem_q    <= '0;
            load_x_q <= 1'b0;
            load_y_q <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE, ERR: begin
                    if (bus.i_start) begin
                        op_q     <= op_t'(bus.i_op);
                        error_q  <= 1'b0;
                        load_x_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= LOAD_X;
                    end else if (state_q == DONE) begin
                        state_q <= IDLE;
                    end
                end
                LOAD_X: begin
                    if (bus.i_load) begin
                        x_q      <= bus.i_data;
                        load_x_q <= 1'b0;
                        if (bad_op) begin
                            error_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ERR;
                        end else if (op_q == OP_ROOT) begin
                            r_q     <= '0;
                            y_q     <= '0;
                            state_q <= CALC;
                        end else begin
                            load_y_q <= 1'b1;
                            state_q  <= LOAD_Y;
                        end
                    end
                end
                LOAD_Y: begin
                    if (bus.i_load) begin
                        y_q      <= bus.i_data;
                        load_y_q <= 1'b0;
                        if (op_q == OP_DIV && bus.i_data == '0) begin
                            error_q <= 1'b1;
                            busy_q  <= 1'b0;
                            res_q   <= '0;
                            rem_q   <= '0;
                            state_q <= ERR;
                        end else begin
                            r_q     <= '0;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (tc) begin
                        res_q   <= res_d;
                        rem_q   <= rem_d;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        x_q <= x_d;
                        y_q <= y_d;
                        r_q <= r_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_load_x    = load_x_q;
    assign bus.o_load_y    = load_y_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_ready     = ready_q;
    assign bus.o_error     = error_q;
    assign bus.o_result    = res_q;
    assign bus.o_remainder = rem_q;

endmodule

// File: tb/tb_mdr_seq_unit.sv
// Directed plus random bench for mdr_seq_unit (DW=16).
// Expected values come from a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_mdr_seq_unit;

    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;
    bit   root_en;

    always #5 clk = ~clk;

    mdr_seq_unit_if #(.DW(DW)) bus ();

    mdr_seq_unit #(.DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: got 0x%0h, want 0x%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ldx"}, bus.o_load_x, 0);
        check({tag, "_ldy"}, bus.o_load_y, 0);
        check({tag, "_busy"}, bus.o_busy, 0);
        check({tag, "_rdy"}, bus.o_ready, 0);
        check({tag, "_err"}, bus.o_error, 0);
        check({tag, "_res"}, bus.o_result, 0);
        check({tag, "_rem"}, bus.o_remainder, 0);
    endtask

    // Reference: what the unit must produce for one operation.
    task automatic model(input logic [1:0] op,
                         input logic [15:0] x, y,
                         output bit err, output bit need_y,
                         output logic [63:0] res,
                         output logic [63:0] rem,
                         output int n);
        logic [63:0] r;
        err    = 0;
        need_y = (op == 2'd0) || (op == 2'd1);
        res    = 0;
        rem    = 0;
        n      = DW;
        case (op)
            2'd0: res = 64'(x) * 64'(y);
            2'd1: begin
                if (y == 0) err = 1;
                else begin
                    res = 64'(x / y);
                    rem = 64'(x % y);
                end
            end
            2'd2: begin
                if (!root_en) err = 1;
                else begin
                    r = 0;
                    while ((r + 1) * (r + 1) <= 64'(x)) r++;
                    res = r;
                    rem = 64'(x) - r * r;
                    n   = DW / 2;
                end
            end
            default: err = 1;
        endcase
    endtask

    task automatic do_op(input logic [1:0] op,
                         input logic [15:0] x, y,
                         input bit poke);
        bit          err, need_y, saw_y;
        logic [63:0] er, em;
        int          n, k;
        model(op, x, y, err, need_y, er, em, n);
        // junk load on the start edge must be ignored
        bus.i_start = 1;
        bus.i_op    = op;
        bus.i_load  = 1;
        bus.i_data  = 16'hA5A5;
        @(negedge clk);
        bus.i_start = 0;
        bus.i_load  = 0;
        check("start_ldx", bus.o_load_x, 1);
        check("start_err", bus.o_error, 0);
        bus.i_load = 1;
        bus.i_data = x;
        @(negedge clk);
        bus.i_load = 0;
        if (need_y) begin
            check("ldy_req", bus.o_load_y, 1);
            bus.i_load = 1;
            bus.i_data = y;
            @(negedge clk);
            bus.i_load = 0;
        end
        if (err) begin
            check("err_flag", bus.o_error, 1);
            check("err_busy", bus.o_busy, 0);
            check("err_ldx", bus.o_load_x, 0);
            if (op == 2'd1) begin
                check("div0_res", bus.o_result, 0);
                check("div0_rem", bus.o_remainder, 0);
            end
            k = 0;
            repeat (20) begin
                @(negedge clk);
                if (bus.o_ready) k++;
            end
            check("err_noready", k, 0);
            check("err_held", bus.o_error, 1);
            return;
        end
        saw_y = 0;
        for (k = 1; k <= 40; k++) begin
            bus.i_start = poke && (k == 4);
            bus.i_op    = poke ? 2'd3 : op;
            @(negedge clk);
            saw_y |= bus.o_load_y;
            if (bus.o_ready) break;
        end
        bus.i_start = 0;
        check("latency", k, n + 1);
        check("result", bus.o_result, er);
        check("remainder", bus.o_remainder, em);
        check("done_busy", bus.o_busy, 0);
        if (!need_y) check("root_noldy", saw_y, 0);
        @(negedge clk);
        check("ready_pulse", bus.o_ready, 0);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [15:0] rx, ry;
`ifdef MDR_ROOT_EN
        root_en = 1;
`else
        root_en = 0;
`endif
        rst         = 1;
        bus.i_start = 0;
        bus.i_load  = 0;
        bus.i_data  = 0;
        bus.i_op    = 0;
        repeat (2) @(negedge clk);
        check_all_zero("rst");
        rst = 0;
        @(negedge clk);
        check_all_zero("post_rst");

        do_op(2'd0, 16'hFFFF, 16'hFFFF, 0);
        do_op(2'd1, 16'd1000, 16'd7, 0);
        do_op(2'd1, 16'd5, 16'd9, 0);
        do_op(2'd1, 16'd5, 16'd0, 0);
        do_op(2'd2, 16'd1000, 16'd0, 0);
        do_op(2'd2, 16'd0, 16'd0, 0);
        do_op(2'd2, 16'hFFFF, 16'd0, 0);
        do_op(2'd3, 16'd123, 16'd4, 0);
        do_op(2'd0, 16'h1234, 16'h00FF, 1);

        // i_load while idle must leave everything alone
        bus.i_load = 1;
        bus.i_data = 16'h7777;
        @(negedge clk);
        bus.i_load = 0;
        @(negedge clk);
        check("idle_ld_res", bus.o_result, 32'h1234 * 32'hFF);
        check("idle_ld_rem", bus.o_remainder, 0);
        check("idle_ld_busy", bus.o_busy, 0);
        check("idle_ld_ldx", bus.o_load_x, 0);

        for (int i = 0; i < 8; i++) begin
            rop = 2'($urandom_range(0, 2));
            rx  = 16'($urandom);
            ry  = ($urandom_range(0, 7) == 0) ? 16'd0
                                              : 16'($urandom);
            do_op(rop, rx, ry, 0);
        end

        // reset in the middle of a MULT
        do_op(2'd0, 16'd3, 16'd5, 0);
        bus.i_start = 1;
        bus.i_op    = 2'd0;
        @(negedge clk);
        bus.i_start = 0;
        bus.i_load  = 1;
        bus.i_data  = 16'hFFFF;
        repeat (2) @(negedge clk);
        bus.i_load = 0;
        repeat (5) @(negedge clk);
        check("pre_rst_busy", bus.o_busy, 1);
        #1 rst = 1;
        #1 check_all_zero("mid_rst");
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        do_op(2'd1, 16'd100, 16'd10, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
